// File: rtl/interupt_source_pkg.sv
// Shared types and sizing helpers for the interrupt source latch.
package interupt_source_pkg;

  localparam int unsigned NUM_CH = 8;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_PENDING = 2'd1,
    CH_HOLDOFF = 2'd2
  } ch_state_t;

  // Holdoff counter width; never narrower than one bit so a zero holdoff still elaborates.
  function automatic int unsigned holdoff_cnt_w(input int unsigned cycles);
    return (cycles == 0) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/interupt_source_channel.sv
// One interrupt channel: pending latch held until ack, post-ack holdoff with a single
// deferred re-fire, and a sticky missed-event flag.
module interupt_source_channel
  import interupt_source_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic evt,
  input  logic ack,
  input  logic missed_clr,
  output logic pending,
  output logic pending_next_c,
  output logic missed
);

  localparam int unsigned CNT_W = holdoff_cnt_w(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             deferred, deferred_nxt;
  logic             missed_set_c;

  // Next-state logic; ack outside PENDING is ignored.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    deferred_nxt = deferred;
    missed_set_c = 1'b0;
    case (state)
      CH_IDLE: begin
        if (evt) state_nxt = CH_PENDING;
      end
      CH_PENDING: begin
        if (ack) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_nxt = evt ? CH_PENDING : CH_IDLE;
          end else begin
            state_nxt    = CH_HOLDOFF;
            cnt_nxt      = CNT_LOAD;
            deferred_nxt = evt;
          end
        end else if (evt) begin
          missed_set_c = 1'b1;
        end
      end
      CH_HOLDOFF: begin
        // Only one re-fire can be deferred; a second edge is reported as missed.
        missed_set_c = evt & deferred;
        if (cnt <= CNT_W'(1)) begin
          state_nxt    = (deferred | evt) ? CH_PENDING : CH_IDLE;
          cnt_nxt      = '0;
          deferred_nxt = 1'b0;
        end else begin
          cnt_nxt      = cnt - CNT_W'(1);
          deferred_nxt = deferred | evt;
        end
      end
      default: begin
        state_nxt    = CH_IDLE;
        cnt_nxt      = '0;
        deferred_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CH_IDLE;
      cnt      <= '0;
      deferred <= 1'b0;
      missed   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      deferred <= deferred_nxt;
      missed   <= missed_set_c | (missed & ~missed_clr);
    end
  end

  assign pending        = (state == CH_PENDING);
  assign pending_next_c = (state_nxt == CH_PENDING);

endmodule

// File: rtl/interupt_source_latch.sv
// Conditions raw peripheral event lines into held, acknowledgeable, maskable interrupt levels.
// Optional input synchronizer: define INTERUPT_SOURCE_SYNC_EN.
module interupt_source_latch
  import interupt_source_pkg::*;
#(
  parameter int unsigned        NUM_CH         = interupt_source_pkg::NUM_CH,
  parameter int unsigned        HOLDOFF_CYCLES = 4,
  parameter logic [NUM_CH-1:0]  MASK_RESET     = '0
) (
  input  logic              system_clock,
  input  logic              system_reset,
  input  logic [NUM_CH-1:0] event_in,
  input  logic              mask_wr,
  input  logic [NUM_CH-1:0] mask_data,
  input  logic [NUM_CH-1:0] missed_clr,
  output logic [NUM_CH-1:0] interupt_out,
  input  logic [NUM_CH-1:0] interupt_ack,
  output logic [NUM_CH-1:0] pending_status,
  output logic [NUM_CH-1:0] missed_status,
  output logic [NUM_CH-1:0] mask_status
);

  logic [NUM_CH-1:0] ev_src;

`ifdef INTERUPT_SOURCE_SYNC_EN
  localparam logic [1:0] ARM_EVALS = 2'd3;

  logic [NUM_CH-1:0] sync1, sync2;

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= event_in;
      sync2 <= sync1;
    end
  end

  assign ev_src = sync2;
`else
  localparam logic [1:0] ARM_EVALS = 2'd1;

  assign ev_src = event_in;
`endif

  logic [NUM_CH-1:0] prev;
  logic [1:0]        arm_cnt;
  logic              armed_c;
  logic [NUM_CH-1:0] edge_c;
  logic [NUM_CH-1:0] mask_nxt_c;
  logic [NUM_CH-1:0] pending_nxt_c;

  // prev resets to 0, so lines already high at release would look like edges;
  // hold off edge detection until prev holds a real sample.
  assign armed_c    = (arm_cnt == ARM_EVALS);
  assign edge_c     = armed_c ? (ev_src & ~prev) : '0;
  assign mask_nxt_c = mask_wr ? mask_data : mask_status;

  always_ff @(posedge system_clock or posedge system_reset) begin
    if (system_reset) begin
      prev         <= '0;
      arm_cnt      <= 2'd0;
      mask_status  <= MASK_RESET;
      interupt_out <= '0;
    end else begin
      prev <= ev_src;
      if (!armed_c) arm_cnt <= arm_cnt + 2'd1;
      mask_status  <= mask_nxt_c;
      interupt_out <= pending_nxt_c & mask_nxt_c;
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    interupt_source_channel #(
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_ch (
      .clk           (system_clock),
      .rst           (system_reset),
      .evt           (edge_c[i]),
      .ack           (interupt_ack[i]),
      .missed_clr    (missed_clr[i]),
      .pending       (pending_status[i]),
      .pending_next_c(pending_nxt_c[i]),
      .missed        (missed_status[i])
    );
  end

endmodule

// File: tb/tb_interupt_source_latch.sv
// Bench for interupt_source_latch: event-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_interupt_source_latch;

  localparam int H = 4;
`ifdef INTERUPT_SOURCE_SYNC_EN
  localparam int LAT = 3;
  localparam int ARM = 3;
`else
  localparam int LAT = 1;
  localparam int ARM = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] event_in = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = '0;
  logic [7:0] missed_clr = '0;
  logic [7:0] ack = '0;
  logic [7:0] interupt_out, pending_status, missed_status, mask_status;

  int tests = 0;
  int fails = 0;

  interupt_source_latch #(
    .NUM_CH(8), .HOLDOFF_CYCLES(H), .MASK_RESET(8'h00)
  ) dut (
    .system_clock  (clk),
    .system_reset  (rst),
    .event_in      (event_in),
    .mask_wr       (mask_wr),
    .mask_data     (mask_data),
    .missed_clr    (missed_clr),
    .interupt_out  (interupt_out),
    .interupt_ack  (ack),
    .pending_status(pending_status),
    .missed_status (missed_status),
    .mask_status   (mask_status)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam logic [1:0] QUIET = 2'd0, RAISED = 2'd1, COOL = 2'd2;
  typedef struct packed {
    logic [1:0] st;
    logic [7:0] left;
    logic       def;
    logic       mis;
  } mch_t;

  function automatic mch_t mstep(mch_t c, logic e, logic a, logic clr);
    mch_t n = c;
    n.mis = c.mis & ~clr;
    case (c.st)
      QUIET:  if (e) n.st = RAISED;
      RAISED: begin
        if (a) begin
          if (H == 0) n.st = e ? RAISED : QUIET;
          else begin
            n.st = COOL; n.left = 8'(H); n.def = e;
          end
        end else if (e) n.mis = 1'b1;
      end
      default: begin
        if (e && c.def) n.mis = 1'b1;
        n.left = c.left - 8'd1;
        n.def  = c.def | e;
        if (n.left == 8'd0) begin
          n.st  = n.def ? RAISED : QUIET;
          n.def = 1'b0;
        end
      end
    endcase
    return n;
  endfunction

  mch_t       m [8];
  logic [7:0] mmask, h1, h2, h3, m_cur, m_prv, m_edge;
  int         cyc;
  logic [7:0] exp_pend, exp_out, exp_mis;

`ifdef INTERUPT_SOURCE_SYNC_EN
  assign m_cur = h2;
  assign m_prv = h3;
`else
  assign m_cur = event_in;
  assign m_prv = h1;
`endif
  assign m_edge = (cyc >= ARM) ? (m_cur & ~m_prv) : 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m[i] <= '0;
      mmask <= 8'h00; h1 <= '0; h2 <= '0; h3 <= '0; cyc <= 0;
    end else begin
      for (int i = 0; i < 8; i++) m[i] <= mstep(m[i], m_edge[i], ack[i], missed_clr[i]);
      mmask <= mask_wr ? mask_data : mmask;
      h1 <= event_in; h2 <= h1; h3 <= h2;
      if (cyc < ARM) cyc <= cyc + 1;
    end
  end

  always_comb begin
    exp_pend = '0;
    exp_mis  = '0;
    for (int i = 0; i < 8; i++) begin
      exp_pend[i] = (m[i].st == RAISED);
      exp_mis[i]  = m[i].mis;
    end
    exp_out = exp_pend & mmask;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_out", 32'(interupt_out), 32'(exp_out));
    chk("model_pend", 32'(pending_status), 32'(exp_pend));
    chk("model_missed", 32'(missed_status), 32'(exp_mis));
    chk("model_mask", 32'(mask_status), 32'(mmask));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tickn(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_mask(input logic [7:0] v);
    mask_wr = 1'b1; mask_data = v;
    tick();
    mask_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit found;
    #23 rst = 1'b0;
    chk("reset_out", 32'(interupt_out), 32'h00);
    chk("reset_pend", 32'(pending_status), 32'h00);
    chk("reset_mask", 32'(mask_status), 32'h00);
    tickn(4);

    // 1: single edge, held level, ack, no refire
    set_mask(8'h01);
    chk("t1_mask", 32'(mask_status), 32'h01);
    event_in = 8'h01;
    tickn(LAT - 1);
    chk("t1_pre", 32'(interupt_out), 32'h00);
    tick();
    chk("t1_rise", 32'(interupt_out), 32'h01);
    tickn(5);
    chk("t1_hold", 32'(interupt_out), 32'h01);
    ack = 8'h01; tick(); ack = 8'h00;
    chk("t1_ack", 32'(interupt_out), 32'h00);
    tickn(15);
    chk("t1_norefire", 32'(pending_status), 32'h00);
    event_in = 8'h00; tickn(4);

    // 2: edge during holdoff fires exactly H cycles after ack
    set_mask(8'hFF);
    event_in = 8'h08; tickn(LAT);
    chk("t2_pend", 32'(pending_status), 32'h08);
    event_in = 8'h00; ack = 8'h08; tick(); ack = 8'h00;
    chk("t2_ackd", 32'(interupt_out), 32'h00);
    tick();
    event_in = 8'h08; tick();
    tick();
    chk("t2_blocked", 32'(pending_status), 32'h00);
    tick();
    chk("t2_refire", 32'(interupt_out), 32'h08);
    chk("t2_nomiss", 32'(missed_status), 32'h00);
    event_in = 8'h00; ack = 8'h08; tick(); ack = 8'h00; tickn(8);

    // 3: ack+edge defers, third edge is missed, set beats clear
    event_in = 8'h20; tickn(LAT);
    chk("t3_pend", 32'(pending_status), 32'h20);
    event_in = 8'h00; tickn(3);
    event_in = 8'h20; tickn(LAT - 1);
    ack = 8'h20; tick(); ack = 8'h00;
    chk("t3_ackedge", 32'(pending_status), 32'h00);
    chk("t3_nomiss", 32'(missed_status), 32'h00);
    event_in = 8'h00; tick();
    event_in = 8'h20; tick();
    tick();
    chk("t3_blocked", 32'(pending_status), 32'h00);
    tick();
    chk("t3_refire", 32'(pending_status), 32'h20);
    chk("t3_missed", 32'(missed_status), 32'h20);
    missed_clr = 8'h20; tick(); missed_clr = 8'h00;
    chk("t3_clr", 32'(missed_status), 32'h00);
    event_in = 8'h00; tickn(3);
    event_in = 8'h20; tickn(LAT - 1);
    missed_clr = 8'h20; tick(); missed_clr = 8'h00;
    chk("t3_setwins", 32'(missed_status), 32'h20);
    missed_clr = 8'h20; tick(); missed_clr = 8'h00;
    chk("t3_clr2", 32'(missed_status), 32'h00);
    event_in = 8'h00; ack = 8'h20; tick(); ack = 8'h00; tickn(8);

    // 4: masked channel latches, unmask releases next cycle
    set_mask(8'h00);
    event_in = 8'h80; tickn(LAT);
    chk("t4_pend", 32'(pending_status), 32'h80);
    chk("t4_masked", 32'(interupt_out), 32'h00);
    set_mask(8'h80);
    chk("t4_unmask", 32'(interupt_out), 32'h80);
    ack = 8'h80; tick(); ack = 8'h00;
    chk("t4_ack", 32'(pending_status), 32'h00);
    event_in = 8'h00; tickn(8);

    // 5: async reset mid-holdoff, no spurious event after release
    event_in = 8'hFF; tickn(LAT);
    chk("t5_pend", 32'(pending_status), 32'hFF);
    chk("t5_out", 32'(interupt_out), 32'h80);
    ack = 8'h0F; tick(); ack = 8'h00;
    chk("t5_partial", 32'(pending_status), 32'hF0);
    tick();
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_out", 32'(interupt_out), 32'h00);
    chk("t5_rst_pend", 32'(pending_status), 32'h00);
    chk("t5_rst_mask", 32'(mask_status), 32'h00);
    @(negedge clk); @(negedge clk); #2 rst = 1'b0;
    tickn(8);
    chk("t5_nospur", 32'(pending_status), 32'h00);
    event_in = 8'h00; tickn(4);

    // 6: edge-to-output latency on every channel
    set_mask(8'hFF);
    for (int i = 0; i < 8; i++) begin
      event_in = 8'h01 << i;
      n = 0; found = 1'b0;
      while (!found && n < 10) begin
        tick(); n++;
        if (pending_status[i]) found = 1'b1;
      end
      chk($sformatf("t6_lat_ch%0d", i), 32'(n), 32'(LAT));
      chk($sformatf("t6_out_ch%0d", i), 32'(interupt_out), 32'(8'h01 << i));
      ack = 8'h01 << i; tick(); ack = 8'h00;
      event_in = 8'h00; tickn(8);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
